alu_seq_exec: RTL

- Registered, area-reduced execute stage directly downstream of the ALU control decoder.
- Accepts the 4-bit ALU operation code, two operands and the branch condition strobes under a valid/ready handshake.
- Produces a registered result, flags and a branch-taken decision.
- Logic, arithmetic and compare ops complete in one cycle; shifts run serially, one bit per cycle, unless `SERIAL_SHIFT`=0.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_serial_shifter.sv | 81 ++++++++
 rtl/alu_seq_exec.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Summary  : Shared op encodings, stage states and branch resolution helper
//            for the ALU execute stage.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int unsigned C_XLEN    = 32;
    localparam int unsigned C_SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SLTU = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SUBU = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SLT  = 4'b1010,
        OP_SRA  = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } exec_state_e;

    // con is packed as {beq, bnq, blt, bgt}; bgt means greater-or-equal.
    function automatic logic branch_resolve(
        input logic       br,
        input logic [3:0] con,
        input logic       z,
        input logic       l
    );
        return br && ((con[3] && z) || (con[2] && !z) ||
                      (con[1] && l) || (con[0] && !l));
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_serial_shifter.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial_shifter
// Summary  : One-bit-per-cycle shifter, or a combinational barrel shifter
//            when SERIAL_SHIFT is 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_serial_shifter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned SHAMT_W      = 5,
    parameter bit          SERIAL_SHIFT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dir,
    input  logic               arith,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [XLEN-1:0]    data,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    data_out
);

    generate
        if (SERIAL_SHIFT) begin : g_serial
            logic [SHAMT_W-1:0] r_cnt;
            logic [XLEN-1:0]    r_data;
            logic               r_dir;
            logic               r_arith;
            logic               w_fill;
            logic [XLEN-1:0]    w_step;

            assign w_fill = r_arith & r_data[XLEN-1];
            assign w_step = r_dir ? {w_fill, r_data[XLEN-1:1]}
                                  : {r_data[XLEN-2:0], 1'b0};

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_data  <= '0;
                    r_dir   <= 1'b0;
                    r_arith <= 1'b0;
                end else if (load) begin
                    r_cnt   <= shamt;
                    r_data  <= data;
                    r_dir   <= dir;
                    r_arith <= arith;
                end else if (r_cnt != '0) begin
                    r_cnt  <= r_cnt - SHAMT_W'(1);
                    r_data <= w_step;
                end
            end

            // data_out already carries the bit moved on this cycle, so the
            // consumer can capture the final value on the done cycle.
            assign busy     = (r_cnt != '0);
            assign done     = (r_cnt == SHAMT_W'(1));
            assign data_out = w_step;
        end else begin : g_barrel
            logic w_unused;

            always_comb begin
                data_out = '0;
                if (!dir) begin
                    data_out = data << shamt;
                end else if (arith) begin
                    data_out = $unsigned($signed(data) >>> shamt);
                end else begin
                    data_out = data >> shamt;
                end
            end

            assign busy     = 1'b0;
            assign done     = load;
            assign w_unused = ^{clk, rst};
        end
    endgenerate

endmodule : alu_serial_shifter
`default_nettype wire

// File: rtl/alu_seq_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_exec
// Summary  : Registered ALU execute stage with valid/ready handshake, flags,
//            branch resolution and an optional bit-serial shifter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN         = C_XLEN,
    parameter int unsigned SHAMT_W      = C_SHAMT_W,
    parameter bit          SERIAL_SHIFT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      operation,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            branch,
    input  logic            con_beq,
    input  logic            con_bnq,
    input  logic            con_blt,
    input  logic            con_bgt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            lt,
    output logic            branch_taken
);

    localparam logic [1:0] c_st_idle  = ST_IDLE;
    localparam logic [1:0] c_st_shift = ST_SHIFT;
    localparam logic [1:0] c_st_done  = ST_DONE;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_lt;
    logic            r_bt;
    logic            r_branch;
    logic [3:0]      r_con;

    alu_op_e          w_op;
    logic             w_accept;
    logic             w_is_shift;
    logic             w_start_serial;
    logic [SHAMT_W-1:0] w_shamt;
    logic [3:0]       w_con;
    logic [XLEN-1:0]  w_diff;
    logic             w_slt;
    logic             w_sltu;
    logic [XLEN-1:0]  w_res;
    logic             w_lt;
    logic             w_zero;
    logic [XLEN-1:0]  w_sh_imm;
    logic [XLEN-1:0]  w_sh_out;
    logic             w_sh_busy;
    logic             w_sh_done;
    logic             w_sh_zero;
    logic             w_unused;

    assign w_op       = alu_op_e'(operation);
    assign w_shamt    = src_b[SHAMT_W-1:0];
    assign w_con      = {con_beq, con_bnq, con_blt, con_bgt};
    assign w_diff     = src_a - src_b;
    assign w_slt      = $signed(src_a) < $signed(src_b);
    assign w_sltu     = src_a < src_b;
    assign w_is_shift = (w_op == OP_SLL) || (w_op == OP_SRL) || (w_op == OP_SRA);

    assign in_ready       = (r_state == c_st_idle) ||
                            ((r_state == c_st_done) && out_ready);
    assign w_accept       = in_valid && in_ready;
    assign w_start_serial = SERIAL_SHIFT && w_is_shift && (w_shamt != '0);

    // In serial mode only a zero-amount shift completes immediately.
    assign w_sh_imm = SERIAL_SHIFT ? src_a : w_sh_out;

    always_comb begin
        w_res = '0;
        w_lt  = 1'b0;
        case (w_op)
            OP_AND:  w_res = src_a & src_b;
            OP_OR:   w_res = src_a | src_b;
            OP_ADD:  w_res = src_a + src_b;
            OP_XOR:  w_res = src_a ^ src_b;
            OP_SUB: begin
                w_res = w_diff;
                w_lt  = w_slt;
            end
            OP_SUBU: begin
                w_res = w_diff;
                w_lt  = w_sltu;
            end
            OP_SLT: begin
                w_res = {{(XLEN-1){1'b0}}, w_slt};
                w_lt  = w_slt;
            end
            OP_SLTU: begin
                w_res = {{(XLEN-1){1'b0}}, w_sltu};
                w_lt  = w_sltu;
            end
            OP_SLL, OP_SRL, OP_SRA: w_res = w_sh_imm;
            default: w_res = '0;
        endcase
    end

    assign w_zero    = (w_res == '0);
    assign w_sh_zero = (w_sh_out == '0);

    alu_serial_shifter #(
        .XLEN         (XLEN),
        .SHAMT_W      (SHAMT_W),
        .SERIAL_SHIFT (SERIAL_SHIFT)
    ) u_shifter (
        .clk      (clk),
        .rst      (reset),
        .load     (w_accept && w_is_shift),
        .dir      ((w_op == OP_SRL) || (w_op == OP_SRA)),
        .arith    (w_op == OP_SRA),
        .shamt    (w_shamt),
        .data     (src_a),
        .busy     (w_sh_busy),
        .done     (w_sh_done),
        .data_out (w_sh_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_lt     <= 1'b0;
            r_bt     <= 1'b0;
            r_branch <= 1'b0;
            r_con    <= '0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (w_accept) begin
                        if (w_start_serial) begin
                            // Branch qualifiers wait for the final shift value.
                            r_state  <= c_st_shift;
                            r_branch <= branch;
                            r_con    <= w_con;
                        end else begin
                            r_state  <= c_st_done;
                            r_result <= w_res;
                            r_zero   <= w_zero;
                            r_lt     <= w_lt;
                            r_bt     <= branch_resolve(branch, w_con, w_zero, w_lt);
                        end
                    end else if ((r_state == c_st_done) && out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_shift: begin
                    if (w_sh_done) begin
                        r_state  <= c_st_done;
                        r_result <= w_sh_out;
                        r_zero   <= w_sh_zero;
                        r_lt     <= 1'b0;
                        r_bt     <= branch_resolve(r_branch, r_con, w_sh_zero, 1'b0);
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign out_valid    = (r_state == c_st_done);
    assign result       = r_result;
    assign zero         = r_zero;
    assign lt           = r_lt;
    assign branch_taken = r_bt;
    assign w_unused     = w_sh_busy;

endmodule : alu_seq_exec
`default_nettype wire
